i2c_target_regs: RTL and testbench

// I2C target (responder) for the dice chip's configuration register space. Answers the bus

---
 rtl/i2c_target_regs_if.sv | 25 ++
 rtl/i2c_target_regs.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_regs_if.sv
// I2C pin and register-port bundle for i2c_target_regs.
// slave = the target block, master = the pads/register file around it.
`timescale 1ns/1ps
interface i2c_target_regs_if;
  logic       sda_in;
  logic       scl_in;
  logic       sda_out;
  logic       sda_oe;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  modport slave (
    input  sda_in, scl_in, rd_data,
    output sda_out, sda_oe, wr_valid, wr_addr, wr_data, rd_addr, busy
  );

  modport master (
    output sda_in, scl_in, rd_data,
    input  sda_out, sda_oe, wr_valid, wr_addr, wr_data, rd_addr, busy
  );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target for the configuration register space: sub-address pointer, write strobes, reads.
// Pins are oversampled on clk (2-FF sync + history FF); SDA is open-drain (pull-low only).
`timescale 1ns/1ps
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR = 7'h70
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  i2c_target_regs_if.slave bus
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_SUB       = 4'd3;
  localparam logic [3:0] S_SUB_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RACK      = 4'd8;
  localparam logic [3:0] S_WAIT_STOP = 4'd9;

  logic       r_sda_s1, r_sda_s2, r_sda_h;
  logic       r_scl_s1, r_scl_s2, r_scl_h;
  logic [3:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_rw;
  logic       r_ack_drv;
  logic       r_mack;
  logic       r_inc_pend;
  logic       r_sda_oe;
  logic       r_busy;
  logic       r_wr_valid;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_rd_addr;

  logic       w_sda;
  logic       w_scl_hi;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_last;
  logic [7:0] w_byte;

  // Sync FFs idle high to match the pulled-up bus, so reset release makes no false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_h  <= 1'b1;
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_h  <= 1'b1;
    end else begin
      r_sda_s1 <= bus.sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_h  <= r_sda_s2;
      r_scl_s1 <= bus.scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_h  <= r_scl_s2;
    end
  end

  assign w_sda      = r_sda_s2;
  assign w_scl_hi   = r_scl_s2 & r_scl_h;
  assign w_scl_rise = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall = ~r_scl_s2 & r_scl_h;
  assign w_start    = w_scl_hi & ~r_sda_s2 & r_sda_h;
  assign w_stop     = w_scl_hi & r_sda_s2 & ~r_sda_h;
  assign w_last     = (r_bit_cnt == 3'd7);
  assign w_byte     = {r_shift[6:0], w_sda};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_rw       <= 1'b0;
      r_ack_drv  <= 1'b0;
      r_mack     <= 1'b0;
      r_inc_pend <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 8'h00;
      r_wr_data  <= 8'h00;
      r_rd_addr  <= 8'h00;
    end else begin
      r_wr_valid <= 1'b0;
      if (r_inc_pend) begin
        r_rd_addr  <= r_rd_addr + 8'd1;
        r_inc_pend <= 1'b0;
      end

      if (!ena) begin
        r_state   <= S_IDLE;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
        r_ack_drv <= 1'b0;
        r_mack    <= 1'b0;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 3'd0;
        r_sda_oe  <= 1'b0;
        r_ack_drv <= 1'b0;
        r_mack    <= 1'b0;
      end else if (w_stop) begin
        r_state   <= S_IDLE;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
        r_ack_drv <= 1'b0;
        r_mack    <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_SUB, S_WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last) begin
                case (r_state)
                  S_ADDR: begin
                    if (w_byte[7:1] == I2C_ADDR) begin
                      r_state <= S_ADDR_ACK;
                      r_rw    <= w_byte[0];
                      r_busy  <= 1'b1;
                    end else begin
                      r_state <= S_WAIT_STOP;
                      r_busy  <= 1'b0;
                    end
                  end
                  S_SUB: begin
                    r_rd_addr <= w_byte;
                    r_state   <= S_SUB_ACK;
                  end
                  default: begin
                    r_wr_valid <= 1'b1;
                    r_wr_addr  <= r_rd_addr;
                    r_wr_data  <= w_byte;
                    r_inc_pend <= 1'b1;
                    r_state    <= S_WDATA_ACK;
                  end
                endcase
              end
            end
          end

          // First SCL fall after the 8th bit pulls SDA for ACK; the second ends the ACK slot.
          S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                r_sda_oe  <= 1'b1;
                r_ack_drv <= 1'b1;
              end else begin
                r_ack_drv <= 1'b0;
                r_bit_cnt <= 3'd0;
                if (r_state == S_ADDR_ACK && r_rw) begin
                  r_shift   <= bus.rd_data;
                  r_rd_addr <= r_rd_addr + 8'd1;
                  r_sda_oe  <= ~bus.rd_data[7];
                  r_state   <= S_RDATA;
                end else begin
                  r_sda_oe <= 1'b0;
                  r_state  <= (r_state == S_ADDR_ACK) ? S_SUB : S_WDATA;
                end
              end
            end
          end

          // Bit counter wraps to 0 on the 8th rise, so a fall with count 0 ends the byte.
          S_RDATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 3'd0) begin
                r_sda_oe <= 1'b0;
                r_mack   <= 1'b0;
                r_state  <= S_RACK;
              end else begin
                r_sda_oe <= ~r_shift[3'd7 - r_bit_cnt];
              end
            end
          end

          S_RACK: begin
            if (w_scl_rise) begin
              if (w_sda) begin
                r_state <= S_WAIT_STOP;
              end else begin
                r_mack <= 1'b1;
              end
            end else if (w_scl_fall && r_mack) begin
              r_mack    <= 1'b0;
              r_bit_cnt <= 3'd0;
              r_shift   <= bus.rd_data;
              r_rd_addr <= r_rd_addr + 8'd1;
              r_sda_oe  <= ~bus.rd_data[7];
              r_state   <= S_RDATA;
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

  assign bus.sda_out  = 1'b0;
  assign bus.sda_oe   = r_sda_oe & ena;
  assign bus.wr_valid = r_wr_valid;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.rd_addr  = r_rd_addr;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, register file on the read port,
// and a byte-level pointer/memory model for expected strobes and read data.
`timescale 1ns/1ps
module tb_i2c_target_regs;
  localparam int Q = 4;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic m_sda = 1'b1;
  logic m_scl = 1'b1;

  i2c_target_regs_if bus();

  i2c_target_regs #(.I2C_ADDR(7'h70)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.sda_in = m_sda & ~bus.sda_oe;
  assign bus.scl_in = m_scl;

  logic [7:0]  mem [0:255];
  logic [15:0] obs [0:1023];
  int unsigned obs_n = 0;
  int unsigned oe_cycles = 0;

  assign bus.rd_data = mem[bus.rd_addr];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.wr_valid) begin
      mem[bus.wr_addr] <= bus.wr_data;
      obs[obs_n[9:0]]  <= {bus.wr_addr, bus.wr_data};
      obs_n            <= obs_n + 1;
    end
    if (bus.sda_oe) oe_cycles <= oe_cycles + 1;
  end

  logic [7:0] model_mem [0:255];
  logic [7:0] model_ptr;
  int n_pass = 0;
  int n_total = 0;

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; clk_n(Q);
    m_scl = 1'b1; clk_n(Q);
    m_sda = 1'b0; clk_n(Q);
    m_scl = 1'b0; clk_n(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; clk_n(Q);
    m_scl = 1'b1; clk_n(Q);
    m_sda = 1'b1; clk_n(Q);
    clk_n(Q);
  endtask

  task automatic drive_bit(input logic b);
    m_sda = b; clk_n(Q);
    m_scl = 1'b1; clk_n(H);
    m_scl = 1'b0; clk_n(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; clk_n(Q);
    m_scl = 1'b1; clk_n(H/2);
    b = bus.sda_in; clk_n(H/2);
    m_scl = 1'b0; clk_n(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic nak);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    read_bit(nak);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nak);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    drive_bit(nak);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_ptr = 8'h00;
    n_total++; if (bus.sda_oe !== 1'b0) $display("FAIL rst_sda_oe got %b want 0", bus.sda_oe); else n_pass++;
    n_total++; if (bus.wr_valid !== 1'b0) $display("FAIL rst_wr_valid got %b want 0", bus.wr_valid); else n_pass++;
    n_total++; if (bus.wr_addr !== 8'h00) $display("FAIL rst_wr_addr got %h want 00", bus.wr_addr); else n_pass++;
    n_total++; if (bus.wr_data !== 8'h00) $display("FAIL rst_wr_data got %h want 00", bus.wr_data); else n_pass++;
    n_total++; if (bus.rd_addr !== 8'h00) $display("FAIL rst_rd_addr got %h want 00", bus.rd_addr); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.sda_out !== 1'b0) $display("FAIL rst_sda_out got %b want 0", bus.sda_out); else n_pass++;
  endtask

  task automatic test_write_basic();
    logic [7:0] bytes [4];
    logic nak;
    int unsigned base;
    bytes = '{8'hE0, 8'h0A, 8'h55, 8'h1F};
    base = obs_n;
    i2c_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], nak);
      n_total++; if (nak !== 1'b0) $display("FAIL wr_ack%0d got %b want 0", i, nak); else n_pass++;
    end
    n_total++; if (bus.busy !== 1'b1) $display("FAIL wr_busy_mid got %b want 1", bus.busy); else n_pass++;
    i2c_stop();
    n_total++; if (bus.busy !== 1'b0) $display("FAIL wr_busy_stop got %b want 0", bus.busy); else n_pass++;
    n_total++; if (obs_n - base !== 2) $display("FAIL wr_nstrobe got %0d want 2", obs_n - base); else n_pass++;
    n_total++; if (obs[base[9:0]] !== 16'h0A55) $display("FAIL wr_strobe0 got %h want 0a55", obs[base[9:0]]); else n_pass++;
    n_total++; if (obs[(base + 1) & 1023] !== 16'h0B1F) $display("FAIL wr_strobe1 got %h want 0b1f", obs[(base + 1) & 1023]); else n_pass++;
    n_total++; if (bus.rd_addr !== 8'h0C) $display("FAIL wr_ptr got %h want 0c", bus.rd_addr); else n_pass++;
    model_mem[8'h0A] = 8'h55; model_mem[8'h0B] = 8'h1F; model_ptr = 8'h0C;
  endtask

  task automatic test_bad_addr();
    logic nak;
    int unsigned base, oe0;
    base = obs_n; oe0 = oe_cycles;
    i2c_start();
    send_byte(8'hE2, nak);
    n_total++; if (nak !== 1'b1) $display("FAIL bad_addr_ack got %b want 1", nak); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL bad_busy got %b want 0", bus.busy); else n_pass++;
    send_byte(8'h11, nak);
    n_total++; if (nak !== 1'b1) $display("FAIL bad_sub_ack got %b want 1", nak); else n_pass++;
    send_byte(8'h22, nak);
    i2c_stop();
    n_total++; if (oe_cycles !== oe0) $display("FAIL bad_oe got %0d want %0d", oe_cycles, oe0); else n_pass++;
    n_total++; if (obs_n !== base) $display("FAIL bad_nstrobe got %0d want %0d", obs_n, base); else n_pass++;
  endtask

  task automatic test_wrap();
    logic nak;
    int unsigned base;
    base = obs_n;
    i2c_start();
    send_byte(8'hE0, nak); send_byte(8'hFF, nak); send_byte(8'hFA, nak); send_byte(8'h4D, nak);
    i2c_stop();
    n_total++; if (obs_n - base !== 2) $display("FAIL wrap_nstrobe got %0d want 2", obs_n - base); else n_pass++;
    n_total++; if (obs[base[9:0]] !== 16'hFFFA) $display("FAIL wrap_strobe0 got %h want fffa", obs[base[9:0]]); else n_pass++;
    n_total++; if (obs[(base + 1) & 1023] !== 16'h004D) $display("FAIL wrap_strobe1 got %h want 004d", obs[(base + 1) & 1023]); else n_pass++;
    n_total++; if (bus.rd_addr !== 8'h01) $display("FAIL wrap_ptr got %h want 01", bus.rd_addr); else n_pass++;
    model_mem[8'hFF] = 8'hFA; model_mem[8'h00] = 8'h4D; model_ptr = 8'h01;
  endtask

  task automatic test_read();
    logic nak, dummy;
    logic [7:0] d;
    int unsigned oe0, base;
    i2c_start();
    send_byte(8'hE0, nak); send_byte(8'h05, nak); send_byte(8'hA5, nak); send_byte(8'h3C, nak);
    i2c_stop();
    model_mem[8'h05] = 8'hA5; model_mem[8'h06] = 8'h3C;
    base = obs_n;
    i2c_start();
    send_byte(8'hE0, nak); send_byte(8'h05, nak);
    i2c_start();
    send_byte(8'hE1, nak);
    n_total++; if (nak !== 1'b0) $display("FAIL rd_addr_ack got %b want 0", nak); else n_pass++;
    recv_byte(d, 1'b0);
    n_total++; if (d !== model_mem[8'h05]) $display("FAIL rd_byte0 got %h want %h", d, model_mem[8'h05]); else n_pass++;
    recv_byte(d, 1'b1);
    n_total++; if (d !== model_mem[8'h06]) $display("FAIL rd_byte1 got %h want %h", d, model_mem[8'h06]); else n_pass++;
    oe0 = oe_cycles;
    for (int i = 0; i < 9; i++) read_bit(dummy);
    n_total++; if (oe_cycles !== oe0) $display("FAIL rd_after_nak_oe got %0d want %0d", oe_cycles, oe0); else n_pass++;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL rd_busy got %b want 1", bus.busy); else n_pass++;
    i2c_stop();
    n_total++; if (bus.rd_addr !== 8'h07) $display("FAIL rd_ptr got %h want 07", bus.rd_addr); else n_pass++;
    n_total++; if (obs_n !== base) $display("FAIL rd_nstrobe got %0d want %0d", obs_n, base); else n_pass++;
    model_ptr = 8'h07;
  endtask

  task automatic test_reset_mid();
    logic nak;
    logic [7:0] d;
    int unsigned base, oe0;
    d = 8'hF0;
    base = obs_n;
    i2c_start();
    send_byte(8'hE0, nak); send_byte(8'h10, nak);
    for (int i = 7; i > 4; i--) drive_bit(d[i]);
    m_sda = d[4]; clk_n(Q);
    m_scl = 1'b1; clk_n(2);
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.sda_oe !== 1'b0) $display("FAIL rstmid_oe got %b want 0", bus.sda_oe); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.rd_addr !== 8'h00) $display("FAIL rstmid_ptr got %h want 00", bus.rd_addr); else n_pass++;
    clk_n(2);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_ptr = 8'h00;
    oe0 = oe_cycles;
    clk_n(H - 4);
    m_scl = 1'b0; clk_n(Q);
    for (int i = 3; i >= 0; i--) drive_bit(d[i]);
    read_bit(nak);
    n_total++; if (nak !== 1'b1) $display("FAIL rstmid_ack got %b want 1", nak); else n_pass++;
    send_byte(8'hE0, nak);
    n_total++; if (nak !== 1'b1) $display("FAIL rstmid_later_ack got %b want 1", nak); else n_pass++;
    i2c_stop();
    n_total++; if (obs_n !== base) $display("FAIL rstmid_nstrobe got %0d want %0d", obs_n, base); else n_pass++;
    n_total++; if (oe_cycles !== oe0) $display("FAIL rstmid_oe_after got %0d want %0d", oe_cycles, oe0); else n_pass++;
  endtask

  task automatic test_restart_mid();
    logic nak;
    logic [7:0] d;
    int unsigned base;
    d = 8'hC3;
    base = obs_n;
    i2c_start();
    send_byte(8'hE0, nak); send_byte(8'h30, nak);
    for (int i = 7; i > 3; i--) drive_bit(d[i]);
    i2c_start();
    send_byte(8'hE0, nak); send_byte(8'h20, nak); send_byte(8'h77, nak);
    i2c_stop();
    n_total++; if (obs_n - base !== 1) $display("FAIL restart_nstrobe got %0d want 1", obs_n - base); else n_pass++;
    n_total++; if (obs[base[9:0]] !== 16'h2077) $display("FAIL restart_strobe got %h want 2077", obs[base[9:0]]); else n_pass++;
    n_total++; if (bus.rd_addr !== 8'h21) $display("FAIL restart_ptr got %h want 21", bus.rd_addr); else n_pass++;
    model_mem[8'h20] = 8'h77; model_ptr = 8'h21;
  endtask

  task automatic test_ena();
    logic nak;
    logic [7:0] a;
    int unsigned base;
    a = 8'hE0;
    base = obs_n;
    i2c_start();
    for (int i = 7; i >= 0; i--) drive_bit(a[i]);
    m_sda = 1'b1;
    n_total++; if (bus.sda_oe !== 1'b1) $display("FAIL ena_ack_drive got %b want 1", bus.sda_oe); else n_pass++;
    ena = 1'b0;
    #1;
    n_total++; if (bus.sda_oe !== 1'b0) $display("FAIL ena_release got %b want 0", bus.sda_oe); else n_pass++;
    clk_n(2);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL ena_busy got %b want 0", bus.busy); else n_pass++;
    ena = 1'b1;
    clk_n(Q);
    m_scl = 1'b1; clk_n(H);
    m_scl = 1'b0; clk_n(Q);
    send_byte(8'h44, nak);
    n_total++; if (nak !== 1'b1) $display("FAIL ena_ignored_ack got %b want 1", nak); else n_pass++;
    i2c_stop();
    n_total++; if (obs_n !== base) $display("FAIL ena_nstrobe got %0d want %0d", obs_n, base); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] d [4];
    logic [7:0] ptr, abyte, rp, got;
    logic nak, nak_or;
    int unsigned n, m, base;
    bit good;
    for (int t = 0; t < 12; t++) begin
      ptr = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      abyte = good ? 8'hE0 : {7'($urandom_range(0, 127)), 1'b0};
      if (abyte[7:1] == 7'h70) begin
        abyte = 8'hE4;
        good = 1'b0;
      end
      base = obs_n;
      i2c_start();
      send_byte(abyte, nak_or);
      send_byte(ptr, nak); nak_or = nak_or | nak;
      for (int i = 0; i < int'(n); i++) begin
        send_byte(d[i], nak);
        nak_or = nak_or | nak;
      end
      i2c_stop();
      n_total++; if (nak_or !== !good) $display("FAIL rnd%0d_ack got %b want %b", t, nak_or, !good); else n_pass++;
      if (good) begin
        model_ptr = ptr;
        for (int i = 0; i < int'(n); i++) begin
          n_total++;
          if (obs[(base + i) & 1023] !== {model_ptr, d[i]})
            $display("FAIL rnd%0d_strobe%0d got %h want %h", t, i, obs[(base + i) & 1023], {model_ptr, d[i]});
          else n_pass++;
          model_mem[model_ptr] = d[i];
          model_ptr = model_ptr + 8'd1;
        end
      end
      n_total++; if (obs_n - base !== (good ? n : 0)) $display("FAIL rnd%0d_nstrobe got %0d want %0d", t, obs_n - base, good ? n : 0); else n_pass++;
      n_total++; if (bus.rd_addr !== model_ptr) $display("FAIL rnd%0d_ptr got %h want %h", t, bus.rd_addr, model_ptr); else n_pass++;

      rp = ptr + 8'($urandom_range(0, 3));
      m = $urandom_range(1, 4);
      i2c_start();
      send_byte(8'hE0, nak); send_byte(rp, nak);
      i2c_start();
      send_byte(8'hE1, nak);
      model_ptr = rp;
      for (int i = 0; i < int'(m); i++) begin
        recv_byte(got, (i == int'(m) - 1));
        n_total++;
        if (got !== model_mem[model_ptr]) $display("FAIL rnd%0d_rd%0d got %h want %h", t, i, got, model_mem[model_ptr]);
        else n_pass++;
        model_ptr = model_ptr + 8'd1;
      end
      i2c_stop();
      n_total++; if (bus.rd_addr !== model_ptr) $display("FAIL rnd%0d_rdptr got %h want %h", t, bus.rd_addr, model_ptr); else n_pass++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clk_n(5);
    test_reset();
    rst_n = 1'b1;
    clk_n(5);
    test_write_basic();
    test_bad_addr();
    test_wrap();
    test_read();
    test_reset_mid();
    test_restart_mid();
    test_ena();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
